// File: rtl/spi_exe_pkg.sv
// Shared definitions for the SPI front-end / exe_unit scheduler slice:
// default widths, flag bit positions and the scheduler state encoding.
package spi_exe_pkg;

    localparam int unsigned M_DEF  = 8;
    localparam int unsigned N_DEF  = 4;
    localparam int unsigned FLAG_W = 4;

    // Flag vector is {BF, NF, OF, SF}
    localparam int unsigned FLAG_SF = 0;
    localparam int unsigned FLAG_OF = 1;
    localparam int unsigned FLAG_NF = 2;
    localparam int unsigned FLAG_BF = 3;

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        EXEC,
        RESP
    } state_t;

endpackage

// File: rtl/exe_sched_rr_pick.sv
// Combinational selector: first set request bit at or after ptr, searching
// upward and wrapping from NREQ-1 back to 0.
module rr_pick
    import spi_exe_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] cand;

    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            cand = IW'((32'(ptr) + i) % NREQ);
            if (!any && req[cand]) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/exe_sched.sv
// Scheduler sharing one exe_unit among NREQ requesters with a valid/ack response.
// Define EXE_SCHED_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module exe_sched
    import spi_exe_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned M    = M_DEF,
    parameter int unsigned N    = N_DEF,
    localparam int unsigned IW  = $clog2(NREQ)
) (
    input  logic                i_clk_p,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ*N-1:0]   i_oper,
    input  logic [NREQ*M-1:0]   i_argA,
    input  logic [NREQ*M-1:0]   i_argB,
    output logic [NREQ-1:0]     o_gnt,
    output logic [N-1:0]        o_exe_oper,
    output logic [M-1:0]        o_exe_argA,
    output logic [M-1:0]        o_exe_argB,
    input  logic [M-1:0]        i_exe_result,
    input  logic [FLAG_W-1:0]   i_exe_flags,
    output logic                o_rsp_valid,
    output logic [IW-1:0]       o_rsp_id,
    output logic [M-1:0]        o_result,
    output logic [FLAG_W-1:0]   o_flags,
    input  logic                i_rsp_ack
);

    state_t        state, state_n;
    logic [IW-1:0] win;
    logic [IW-1:0] pick_ptr;
    logic [IW-1:0] pick_idx;
    logic          pick_any;

`ifdef EXE_SCHED_FIXED_PRIO_EN
    assign pick_ptr = '0;
`else
    logic [IW-1:0] ptr;

    // Pointer only advances once the owner has accepted its response.
    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            ptr <= '0;
        end else if (state == RESP && i_rsp_ack) begin
            ptr <= (win == IW'(NREQ - 1)) ? '0 : win + 1'b1;
        end
    end

    assign pick_ptr = ptr;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req (i_req),
        .ptr (pick_ptr),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n     = state;
        o_gnt       = '0;
        o_rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (pick_any) begin
                    state_n = GRANT;
                end
            end
            GRANT: begin
                o_gnt[win] = 1'b1;
                state_n    = EXEC;
            end
            EXEC: begin
                state_n = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ack) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk_p or posedge i_rst) begin
        if (i_rst) begin
            win        <= '0;
            o_exe_oper <= '0;
            o_exe_argA <= '0;
            o_exe_argB <= '0;
            o_result   <= '0;
            o_flags    <= '0;
            o_rsp_id   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        win <= pick_idx;
                    end
                end
                GRANT: begin
                    o_exe_oper <= i_oper[win*N +: N];
                    o_exe_argA <= i_argA[win*M +: M];
                    o_exe_argB <= i_argB[win*M +: M];
                end
                EXEC: begin
                    o_result <= i_exe_result;
                    o_flags  <= i_exe_flags;
                    o_rsp_id <= win;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exe_sched.sv
// Self-checking bench for exe_sched with an XOR exe_unit stub (flags fixed at 4'hA).
module tb_exe_sched;

    localparam int NREQ = 4;
    localparam int M    = 8;
    localparam int N    = 4;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*N-1:0] oper_bus;
    logic [NREQ*M-1:0] a_bus;
    logic [NREQ*M-1:0] b_bus;
    logic [NREQ-1:0]   gnt;
    logic [N-1:0]      exe_oper;
    logic [M-1:0]      exe_a;
    logic [M-1:0]      exe_b;
    logic [M-1:0]      exe_res;
    logic [3:0]        exe_flags;
    logic              rsp_valid;
    logic [IW-1:0]     rsp_id;
    logic [M-1:0]      result;
    logic [3:0]        flags;
    logic              ack;

    logic [N-1:0] opc [NREQ];
    logic [M-1:0] opA [NREQ];
    logic [M-1:0] opB [NREQ];

    int n_cmp = 0;
    int n_err = 0;
    int mptr  = 0;

    always #5 clk = ~clk;

    always_comb begin
        oper_bus = '0;
        a_bus    = '0;
        b_bus    = '0;
        for (int k = 0; k < NREQ; k++) begin
            oper_bus[k*N +: N] = opc[k];
            a_bus[k*M +: M]    = opA[k];
            b_bus[k*M +: M]    = opB[k];
        end
    end

    assign exe_res   = exe_a ^ exe_b;
    assign exe_flags = 4'hA;

    exe_sched #(
        .NREQ (NREQ),
        .M    (M),
        .N    (N)
    ) dut (
        .i_clk_p      (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_oper       (oper_bus),
        .i_argA       (a_bus),
        .i_argB       (b_bus),
        .o_gnt        (gnt),
        .o_exe_oper   (exe_oper),
        .o_exe_argA   (exe_a),
        .o_exe_argB   (exe_b),
        .i_exe_result (exe_res),
        .i_exe_flags  (exe_flags),
        .o_rsp_valid  (rsp_valid),
        .o_rsp_id     (rsp_id),
        .o_result     (result),
        .o_flags      (flags),
        .i_rsp_ack    (ack)
    );

    // Reference arbitration: scan from the pointer, wrapping.
    function automatic int model_pick(logic [NREQ-1:0] r, int p);
        int base;
        base = p;
`ifdef EXE_SCHED_FIXED_PRIO_EN
        base = 0;
`endif
        for (int off = 0; off < NREQ; off++) begin
            if (r[(base + off) % NREQ]) return (base + off) % NREQ;
        end
        return 0;
    endfunction

    function automatic int model_next_ptr(int w);
`ifdef EXE_SCHED_FIXED_PRIO_EN
        return 0;
`else
        return (w + 1) % NREQ;
`endif
    endfunction

    function automatic logic [NREQ-1:0] onehot(int w);
        logic [NREQ-1:0] v;
        v    = '0;
        v[w] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_ops();
        for (int k = 0; k < NREQ; k++) begin
            opc[k] = N'($urandom);
            opA[k] = M'($urandom);
            opB[k] = M'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        repeat (2) tick();
        rst  = 1'b0;
        mptr = 0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        rand_ops();
        repeat (2) tick();
        n_cmp++;
        if ({gnt, rsp_valid, exe_oper, exe_a, exe_b, result, flags, rsp_id} !== '0) begin
            n_err++;
            $display("FAIL reset_state: got gnt=%b v=%b op=%h a=%h b=%h r=%h f=%h id=%0d, expected all zero",
                     gnt, rsp_valid, exe_oper, exe_a, exe_b, result, flags, rsp_id);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        do_reset();
        opc[2] = 4'h3;
        opA[2] = 8'h5A;
        opB[2] = 8'h0F;
        ack    = 1'b1;
        req    = 4'b0100;
        tick();
        n_cmp++;
        if (gnt !== 4'b0100 || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b valid=%b, expected gnt=0100 valid=0", gnt, rsp_valid);
        end
        req = '0;
        tick();
        n_cmp++;
        if (exe_oper !== 4'h3 || exe_a !== 8'h5A || exe_b !== 8'h0F || rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_exec: op=%h a=%h b=%h valid=%b, expected 3 5a 0f 0", exe_oper, exe_a, exe_b, rsp_valid);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b1 || result !== 8'h55 || flags !== 4'hA || rsp_id !== 2'd2) begin
            n_err++;
            $display("FAIL single_resp: valid=%b r=%h f=%h id=%0d, expected 1 55 a 2", rsp_valid, result, flags, rsp_id);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0 || gnt !== '0) begin
            n_err++;
            $display("FAIL single_done: valid=%b gnt=%b, expected 0 0000", rsp_valid, gnt);
        end
        mptr = model_next_ptr(2);
    endtask

    task automatic test_all_req();
        int cyc, last, waited, exp_w;
        do_reset();
        rand_ops();
        ack  = 1'b1;
        req  = '1;
        cyc  = 0;
        last = 0;
        for (int g = 0; g < 5; g++) begin
            waited = 0;
            do begin
                tick();
                cyc++;
                waited++;
            end while (gnt == '0 && waited < 8);
            exp_w = model_pick(req, mptr);
            n_cmp++;
            if (gnt !== onehot(exp_w)) begin
                n_err++;
                $display("FAIL all_req_grant%0d: gnt=%b, expected %b", g, gnt, onehot(exp_w));
            end
            if (g > 0) begin
                n_cmp++;
                if (cyc - last != 4) begin
                    n_err++;
                    $display("FAIL all_req_spacing%0d: interval=%0d, expected 4", g, cyc - last);
                end
            end
            last = cyc;
            mptr = model_next_ptr(exp_w);
        end
        req = '0;
    endtask

    task automatic test_backpressure();
        int k, other;
        logic [M-1:0] er;
        do_reset();
        rand_ops();
        k     = $urandom_range(0, NREQ - 1);
        other = (k + 1 + $urandom_range(0, NREQ - 2)) % NREQ;
        er    = opA[k] ^ opB[k];
        ack   = 1'b0;
        req   = onehot(k);
        tick();
        n_cmp++;
        if (gnt !== onehot(model_pick(onehot(k), mptr))) begin
            n_err++;
            $display("FAIL bp_grant: gnt=%b, expected %b", gnt, onehot(k));
        end
        req = onehot(other);
        tick();
        tick();
        for (int c = 0; c < 6; c++) begin
            n_cmp++;
            if ({rsp_valid, result, flags, 32'(rsp_id), gnt} !== {1'b1, er, 4'hA, k, 4'b0000}) begin
                n_err++;
                $display("FAIL bp_hold%0d: valid=%b r=%h f=%h id=%0d gnt=%b, expected 1 %h a %0d 0000",
                         c, rsp_valid, result, flags, rsp_id, gnt, er, k);
            end
            if (c < 5) tick();
        end
        ack = 1'b1;
        tick();
        ack  = 1'b0;
        mptr = model_next_ptr(k);
        n_cmp++;
        if (rsp_valid !== 1'b0 || gnt !== '0) begin
            n_err++;
            $display("FAIL bp_after_ack: valid=%b gnt=%b, expected 0 0000", rsp_valid, gnt);
        end
        tick();
        n_cmp++;
        if (gnt !== onehot(model_pick(req, mptr))) begin
            n_err++;
            $display("FAIL bp_next_grant: gnt=%b, expected %b", gnt, onehot(model_pick(req, mptr)));
        end
        req = '0;
    endtask

    task automatic test_wrap();
        int waited, exp_w;
        do_reset();
        rand_ops();
        ack = 1'b1;
        req = 4'b0100;
        tick();
        req = '0;
        repeat (3) tick();
        mptr = model_next_ptr(2);
        req  = 4'b1001;
        for (int g = 0; g < 2; g++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (gnt == '0 && waited < 8);
            exp_w = model_pick(req, mptr);
            n_cmp++;
            if (gnt !== onehot(exp_w)) begin
                n_err++;
                $display("FAIL wrap_grant%0d: gnt=%b, expected %b", g, gnt, onehot(exp_w));
            end
            req[exp_w] = 1'b0;
            tick();
            tick();
            n_cmp++;
            if ({rsp_valid, 32'(rsp_id), result} !== {1'b1, exp_w, opA[exp_w] ^ opB[exp_w]}) begin
                n_err++;
                $display("FAIL wrap_resp%0d: valid=%b id=%0d r=%h, expected 1 %0d %h",
                         g, rsp_valid, rsp_id, result, exp_w, opA[exp_w] ^ opB[exp_w]);
            end
            mptr = model_next_ptr(exp_w);
        end
        tick();
    endtask

    task automatic test_reset_exec();
        int w, bad;
        do_reset();
        rand_ops();
        ack = 1'b1;
        req = 4'b0100;
        tick();
        req = '0;
        repeat (3) tick();
        mptr = model_next_ptr(2);
        req  = 4'b1010;
        tick();
        w = model_pick(req, mptr);
        n_cmp++;
        if (gnt !== onehot(w)) begin
            n_err++;
            $display("FAIL rexec_grant: gnt=%b, expected %b", gnt, onehot(w));
        end
        req = '0;
        tick();
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if ({gnt, rsp_valid, exe_oper, exe_a, exe_b, result, flags, rsp_id} !== '0) begin
            n_err++;
            $display("FAIL rexec_async_clear: gnt=%b v=%b op=%h a=%h b=%h r=%h f=%h id=%0d, expected all zero",
                     gnt, rsp_valid, exe_oper, exe_a, exe_b, result, flags, rsp_id);
        end
        tick();
        rst  = 1'b0;
        mptr = 0;
        bad  = 0;
        for (int c = 0; c < 4; c++) begin
            if (rsp_valid !== 1'b0 || gnt !== '0) bad++;
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL rexec_no_resp: %0d active cycles after reset, expected 0", bad);
        end
        req = 4'b1010;
        tick();
        n_cmp++;
        if (gnt !== onehot(model_pick(4'b1010, mptr))) begin
            n_err++;
            $display("FAIL rexec_ptr0: gnt=%b, expected %b", gnt, onehot(model_pick(4'b1010, mptr)));
        end
        req = '0;
    endtask

    task automatic test_withdraw();
        int k;
        logic [N-1:0] so;
        logic [M-1:0] sa, sb;
        do_reset();
        rand_ops();
        k   = $urandom_range(0, NREQ - 1);
        so  = opc[k];
        sa  = opA[k];
        sb  = opB[k];
        ack = 1'b1;
        req = onehot(k);
        tick();
        n_cmp++;
        if (gnt !== onehot(k)) begin
            n_err++;
            $display("FAIL wd_grant: gnt=%b, expected %b", gnt, onehot(k));
        end
        req = '0;
        tick();
        opc[k] = ~so;
        opA[k] = ~sa;
        opB[k] = sb + 8'd1;
        n_cmp++;
        if ({exe_oper, exe_a, exe_b} !== {so, sa, sb}) begin
            n_err++;
            $display("FAIL wd_exec: op=%h a=%h b=%h, expected %h %h %h", exe_oper, exe_a, exe_b, so, sa, sb);
        end
        tick();
        n_cmp++;
        if ({rsp_valid, 32'(rsp_id), result} !== {1'b1, k, sa ^ sb}) begin
            n_err++;
            $display("FAIL wd_resp: valid=%b id=%0d r=%h, expected 1 %0d %h", rsp_valid, rsp_id, result, k, sa ^ sb);
        end
        tick();
    endtask

    task automatic test_random();
        int waited, w, d, bad;
        logic [N-1:0]    so;
        logic [M-1:0]    sa, sb;
        logic [NREQ-1:0] add;
        do_reset();
        rand_ops();
        req = NREQ'($urandom);
        if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            waited = 0;
            do begin
                tick();
                waited++;
            end while (gnt == '0 && waited < 8);
            if (gnt == '0) begin
                n_cmp++;
                n_err++;
                $display("FAIL rnd_timeout%0d: gnt=%b after %0d cycles, expected a grant", t, gnt, waited);
                break;
            end
            w = model_pick(req, mptr);
            n_cmp++;
            if (gnt !== onehot(w)) begin
                n_err++;
                $display("FAIL rnd_grant%0d: gnt=%b, expected %b", t, gnt, onehot(w));
            end
            so     = opc[w];
            sa     = opA[w];
            sb     = opB[w];
            req[w] = 1'b0;
            tick();
            n_cmp++;
            if ({exe_oper, exe_a, exe_b} !== {so, sa, sb}) begin
                n_err++;
                $display("FAIL rnd_exec%0d: op=%h a=%h b=%h, expected %h %h %h", t, exe_oper, exe_a, exe_b, so, sa, sb);
            end
            tick();
            n_cmp++;
            if ({rsp_valid, 32'(rsp_id), result, flags} !== {1'b1, w, sa ^ sb, 4'hA}) begin
                n_err++;
                $display("FAIL rnd_resp%0d: valid=%b id=%0d r=%h f=%h, expected 1 %0d %h a",
                         t, rsp_valid, rsp_id, result, flags, w, sa ^ sb);
            end
            d   = $urandom_range(0, 3);
            bad = 0;
            for (int c = 0; c < d; c++) begin
                tick();
                if (rsp_valid !== 1'b1 || result !== (sa ^ sb) || gnt !== '0) bad++;
            end
            if (d > 0) begin
                n_cmp++;
                if (bad != 0) begin
                    n_err++;
                    $display("FAIL rnd_hold%0d: %0d unstable cycles, expected 0", t, bad);
                end
            end
            ack = 1'b1;
            tick();
            ack  = 1'b0;
            mptr = model_next_ptr(w);
            add  = NREQ'($urandom) & ~req;
            for (int k = 0; k < NREQ; k++) begin
                if (add[k]) begin
                    opc[k] = N'($urandom);
                    opA[k] = M'($urandom);
                    opB[k] = M'($urandom);
                end
            end
            req = req | add;
            if (req == '0) req[$urandom_range(0, NREQ - 1)] = 1'b1;
        end
        req = '0;
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        ack = 1'b0;
        rand_ops();
        test_reset();
        test_single();
        test_all_req();
        test_backpressure();
        test_wrap();
        test_reset_exec();
        test_withdraw();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
